// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key event receiver: prefix byte values,
// receiver state encoding, event record layout and a parity helper.
package ps2_pkg;

   localparam logic [7:0]  PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0]  PS2_REL_PREFIX = 8'hF0;
   localparam int unsigned EVT_W          = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } rx_state_e;

   // One queued key event; field order matches {ext, rel, code}.
   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } ps2_evt_t;

   // True when data bits plus parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO with a registered head.
// Ports:
//   clk, clrn      clock, asynchronous active-low reset
//   push, wdata    write request and record
//   pop            consumer ready; only acts while rvalid is high
//   rvalid, rdata  registered head-valid flag and head record
//   drop_c         combinational: a push was refused because the FIFO was full
module ps2_evt_fifo #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned WIDTH      = 10
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             rvalid,
   output logic [WIDTH-1:0] rdata,
   output logic             drop_c
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_next_c;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next_c;
   logic             full_c;
   logic             pop_acc_c;
   logic             push_acc_c;

   // Accept/refuse decisions; a pop frees a slot for a push in the same cycle.
   always_comb begin
      full_c       = (count == CNT_W'(FIFO_DEPTH));
      pop_acc_c    = pop & rvalid;
      push_acc_c   = push & (~full_c | pop_acc_c);
      drop_c       = push & ~push_acc_c;
      rd_next_c    = rd_ptr + PTR_W'(pop_acc_c);
      count_next_c = count + CNT_W'(push_acc_c) - CNT_W'(pop_acc_c);
   end

   // Pointers, occupancy and the registered head.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         if (push_acc_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_next_c;
         count  <= count_next_c;
         rvalid <= (count_next_c != '0);
         // The next head is the record being written when it lands in the head slot.
         if (count_next_c != '0) begin
            rdata <= (push_acc_c && (rd_next_c == wr_ptr)) ? wdata : mem[rd_next_c];
         end
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (push_acc_c) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronises the raw bus, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues key events.
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   ps2_clk, ps2_data         raw PS/2 bus (asynchronous)
//   evt_valid, evt_ready      event handshake
//   evt_code/release/ext      head event fields
//   overflow, overflow_clr    sticky drop flag and its synchronous clear
//   frame_err                 one-cycle pulse on a rejected or aborted frame
module ps2_key_event_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_release,
   output logic       evt_ext,
   output logic       overflow,
   input  logic       overflow_clr,
   output logic       frame_err
);

   localparam int unsigned SYNC_N     = 3;
   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_N-1:0] clk_sync;
   logic [SYNC_N-1:0] data_sync;
   logic              clk_prev;
   logic              fall_c;
   logic              data_s_c;

   rx_state_e         state;
   logic [3:0]        bit_cnt;
   logic [9:0]        frame_sr;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              pending_ext;
   logic              pending_rel;

   logic [7:0]        rx_byte_c;
   logic              frame_ok_c;
   logic              push_c;
   ps2_evt_t          push_evt_c;
   logic              drop_c;
   logic [EVT_W-1:0]  head_bits;
   ps2_evt_t          head_evt;

   // Bus synchronisers; clk_prev provides the edge-detect history.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_N-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_N-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_N-1];
      end
   end

   assign fall_c   = clk_prev & ~clk_sync[SYNC_N-1];
   assign data_s_c = data_sync[SYNC_N-1];

   // Frame decode; frame_sr holds {stop, parity, data[7:0]} after the last shift.
   always_comb begin
      rx_byte_c       = frame_sr[7:0];
      frame_ok_c      = odd_parity_ok(frame_sr[8:0]) & frame_sr[9];
      push_evt_c.ext  = pending_ext;
      push_evt_c.rel  = pending_rel;
      push_evt_c.code = rx_byte_c;
      push_c          = 1'b0;
      if ((state == CHECK) && frame_ok_c &&
          (rx_byte_c != PS2_EXT_PREFIX) && (rx_byte_c != PS2_REL_PREFIX)) begin
         push_c = 1'b1;
      end
   end

   // Receiver FSM with timeout and prefix tracking.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         frame_sr    <= '0;
         tmo_cnt     <= '0;
         pending_ext <= 1'b0;
         pending_rel <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (fall_c) begin
                  if (!data_s_c) begin
                     state   <= SHIFT;
                     bit_cnt <= '0;
                     tmo_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (fall_c) begin
                  frame_sr <= {data_s_c, frame_sr[9:1]};
                  tmo_cnt  <= '0;
                  bit_cnt  <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                     state <= CHECK;
                  end
               end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                  state     <= IDLE;
                  tmo_cnt   <= '0;
                  frame_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            CHECK: begin
               state <= IDLE;
               if (!frame_ok_c) begin
                  frame_err <= 1'b1;
               end else if (rx_byte_c == PS2_EXT_PREFIX) begin
                  pending_ext <= 1'b1;
               end else if (rx_byte_c == PS2_REL_PREFIX) begin
                  pending_rel <= 1'b1;
               end else begin
                  pending_ext <= 1'b0;
                  pending_rel <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky overflow; a drop wins over a same-cycle clear.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         overflow <= 1'b0;
      end else if (drop_c) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

   ps2_evt_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (EVT_W)
   ) u_fifo (
      .clk    (clk),
      .clrn   (clrn),
      .push   (push_c),
      .wdata  (push_evt_c),
      .pop    (evt_ready),
      .rvalid (evt_valid),
      .rdata  (head_bits),
      .drop_c (drop_c)
   );

   assign head_evt    = ps2_evt_t'(head_bits);
   assign evt_code    = head_evt.code;
   assign evt_release = head_evt.rel;
   assign evt_ext     = head_evt.ext;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Bench for ps2_key_event_rx: directed scenarios plus a randomized frame
// stream compared against a queue-based model of the key event protocol.
module tb_ps2_key_event_rx;
   import ps2_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 300;
   localparam int          HALF  = 16;

   logic       clk = 1'b0;
   logic       clrn;
   logic       ps2_clk;
   logic       ps2_data;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_release;
   logic       evt_ext;
   logic       overflow;
   logic       overflow_clr;
   logic       frame_err;

   int n_total = 0;
   int n_pass  = 0;
   int err_cnt = 0;

   // Reference model state: queued {ext, rel, code}, pending prefixes, overflow.
   logic [9:0] mq[$];
   bit         m_ext;
   bit         m_rel;
   bit         m_ovf;

   always #5 clk = ~clk;

   ps2_key_event_rx #(
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .clrn         (clrn),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_release  (evt_release),
      .evt_ext      (evt_ext),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .frame_err    (frame_err)
   );

   always @(posedge clk) begin
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Device-side frame: start, 8 data LSB first, odd parity, stop.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         wait_clks(HALF);
         ps2_clk = 1'b0;
         wait_clks(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_clks(4);
   endtask

   task automatic model_byte(input logic [7:0] b, input bit bad);
      if (bad) return;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else begin
         if (mq.size() < DEPTH) mq.push_back({m_ext, m_rel, b});
         else m_ovf = 1'b1;
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_ovf = 1'b0;
   endtask

   // Captures the head as {valid, ext, rel, code} and pops it.
   task automatic pop_event(output logic [10:0] obs);
      obs = {evt_valid, evt_ext, evt_release, evt_code};
      evt_ready = 1'b1;
      wait_clks(1);
      evt_ready = 1'b0;
   endtask

   // Drives ready/clear during the single receiver CHECK cycle.
   task automatic pulse_at_check(input bit rdy, input bit clr);
      int k;
      k = 0;
      while (dut.state !== CHECK && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (dut.state !== CHECK) begin
         n_total++;
         $display("FAIL check_wait: receiver never reached CHECK");
      end else begin
         evt_ready    = rdy;
         overflow_clr = clr;
         wait_clks(1);
         evt_ready    = 1'b0;
         overflow_clr = 1'b0;
      end
   endtask

   task automatic test_reset();
      clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      evt_ready = 1'b0; overflow_clr = 1'b0;
      model_clear();
      wait_clks(5);
      n_total++;
      if ({evt_valid, overflow, frame_err} !== 3'b000)
         $display("FAIL reset_flags: got %b expected 000", {evt_valid, overflow, frame_err});
      else n_pass++;
      n_total++;
      if ({evt_ext, evt_release, evt_code} !== 10'h000)
         $display("FAIL reset_head: got %h expected 000", {evt_ext, evt_release, evt_code});
      else n_pass++;
      clrn = 1'b1;
      wait_clks(5);
      n_total++;
      if ({evt_valid, overflow, frame_err} !== 3'b000)
         $display("FAIL post_reset_flags: got %b expected 000", {evt_valid, overflow, frame_err});
      else n_pass++;
   endtask

   task automatic test_single_make();
      logic [10:0] obs;
      int k;
      fork
         send_frame(8'h1C, 1'b0, 11);
         begin
            k = 0;
            while (dut.state !== CHECK && k < 2000) begin
               @(negedge clk);
               k++;
            end
            n_total++;
            if (dut.state !== CHECK || evt_valid !== 1'b0)
               $display("FAIL single_in_check: valid %b state %0d expected valid 0 in CHECK", evt_valid, dut.state);
            else n_pass++;
            wait_clks(1);
            n_total++;
            if (evt_valid !== 1'b1)
               $display("FAIL single_latency: valid %b expected 1 one cycle after CHECK", evt_valid);
            else n_pass++;
         end
      join
      pop_event(obs);
      n_total++;
      if (obs !== {1'b1, 2'b00, 8'h1C}) $display("FAIL single_event: got %h expected %h", obs, {1'b1, 2'b00, 8'h1C});
      else n_pass++;
      n_total++;
      if (evt_valid !== 1'b0) $display("FAIL single_empty: valid %b expected 0", evt_valid);
      else n_pass++;
   endtask

   task automatic test_prefix();
      logic [10:0] obs;
      int e0;
      e0 = err_cnt;
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'hF0, 1'b0, 11);
      n_total++;
      if (evt_valid !== 1'b0) $display("FAIL prefix_no_push: valid %b expected 0", evt_valid);
      else n_pass++;
      send_frame(8'h75, 1'b0, 11);
      pop_event(obs);
      n_total++;
      if (obs !== {1'b1, 2'b11, 8'h75}) $display("FAIL prefix_event: got %h expected %h", obs, {1'b1, 2'b11, 8'h75});
      else n_pass++;
      send_frame(8'h1C, 1'b0, 11);
      pop_event(obs);
      n_total++;
      if (obs !== {1'b1, 2'b00, 8'h1C}) $display("FAIL prefix_cleared: got %h expected %h", obs, {1'b1, 2'b00, 8'h1C});
      else n_pass++;
      n_total++;
      if (err_cnt !== e0) $display("FAIL prefix_errs: got %0d expected %0d", err_cnt, e0);
      else n_pass++;
   endtask

   task automatic test_bad_parity();
      logic [10:0] obs;
      int e0;
      e0 = err_cnt;
      send_frame(8'h1C, 1'b1, 11);
      n_total++;
      if (err_cnt !== e0 + 1) $display("FAIL parity_err_pulse: got %0d expected %0d", err_cnt, e0 + 1);
      else n_pass++;
      n_total++;
      if (evt_valid !== 1'b0) $display("FAIL parity_no_event: valid %b expected 0", evt_valid);
      else n_pass++;
      send_frame(8'h1C, 1'b0, 11);
      pop_event(obs);
      n_total++;
      if (obs !== {1'b1, 2'b00, 8'h1C}) $display("FAIL parity_recover: got %h expected %h", obs, {1'b1, 2'b00, 8'h1C});
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [7:0] codes [4];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D};
      for (int i = 0; i < 4; i++) send_frame(codes[i], 1'b0, 11);
      n_total++;
      if (overflow !== 1'b0) $display("FAIL ovf_not_yet: got %b expected 0", overflow);
      else n_pass++;
      // Fifth event dropped while a clear is requested in the same cycle.
      fork
         send_frame(8'h2C, 1'b0, 11);
         pulse_at_check(1'b0, 1'b1);
      join
      n_total++;
      if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow);
      else n_pass++;
      n_total++;
      if ({evt_valid, evt_code} !== {1'b1, 8'h15}) $display("FAIL ovf_head_hold: got %h expected %h", {evt_valid, evt_code}, {1'b1, 8'h15});
      else n_pass++;
      overflow_clr = 1'b1;
      wait_clks(1);
      overflow_clr = 1'b0;
      wait_clks(1);
      n_total++;
      if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow);
      else n_pass++;
   endtask

   task automatic test_full_push_pop();
      logic [10:0] obs;
      logic [7:0]  exp [4];
      exp = '{8'h1D, 8'h24, 8'h2D, 8'h35};
      fork
         send_frame(8'h35, 1'b0, 11);
         pulse_at_check(1'b1, 1'b0);
      join
      n_total++;
      if (overflow !== 1'b0) $display("FAIL full_pp_ovf: got %b expected 0", overflow);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         pop_event(obs);
         n_total++;
         if (obs !== {3'b100, exp[i]}) $display("FAIL full_pp_order%0d: got %h expected %h", i, obs, {3'b100, exp[i]});
         else n_pass++;
      end
      n_total++;
      if (evt_valid !== 1'b0) $display("FAIL full_pp_empty: valid %b expected 0", evt_valid);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [10:0] obs;
      int e0;
      int cyc;
      e0 = err_cnt;
      send_frame(8'hA5, 1'b0, 4);
      cyc = 0;
      while (err_cnt == e0 && cyc < int'(TMO) + 100) begin
         wait_clks(1);
         cyc++;
      end
      n_total++;
      if (err_cnt !== e0 + 1) $display("FAIL timeout_pulse: got %0d expected %0d", err_cnt, e0 + 1);
      else n_pass++;
      n_total++;
      if (cyc < int'(TMO) - HALF - 4 || cyc > int'(TMO) - HALF + 6)
         $display("FAIL timeout_time: got %0d cycles expected about %0d", cyc, int'(TMO) - HALF + 1);
      else n_pass++;
      n_total++;
      if (dut.state !== IDLE) $display("FAIL timeout_idle: state %0d expected IDLE", dut.state);
      else n_pass++;
      send_frame(8'h5A, 1'b0, 11);
      pop_event(obs);
      n_total++;
      if (obs !== {1'b1, 2'b00, 8'h5A}) $display("FAIL timeout_recover: got %h expected %h", obs, {1'b1, 2'b00, 8'h5A});
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      logic [10:0] obs;
      int e0;
      send_frame(8'h1C, 1'b0, 11);
      send_frame(8'h32, 1'b0, 11);
      send_frame(8'h4B, 1'b0, 3);
      clrn = 1'b0;
      #1;
      n_total++;
      if ({evt_valid, evt_code} !== 9'h000) $display("FAIL rst_mid_async: got %h expected 000", {evt_valid, evt_code});
      else n_pass++;
      wait_clks(3);
      clrn = 1'b1;
      model_clear();
      wait_clks(3);
      e0 = err_cnt;
      send_frame(8'h29, 1'b0, 11);
      pop_event(obs);
      n_total++;
      if (obs !== {1'b1, 2'b00, 8'h29}) $display("FAIL rst_mid_event: got %h expected %h", obs, {1'b1, 2'b00, 8'h29});
      else n_pass++;
      n_total++;
      if (evt_valid !== 1'b0 || err_cnt !== e0)
         $display("FAIL rst_mid_single: valid %b errs %0d expected 0 and %0d", evt_valid, err_cnt, e0);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [10:0] obs;
      logic [9:0]  exp;
      logic [7:0]  b;
      bit          bad;
      int          r;
      int          e0;
      model_clear();
      for (int f = 0; f < 40; f++) begin
         r = int'($urandom_range(0, 5));
         b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 7) == 0);
         e0 = err_cnt;
         send_frame(b, bad, 11);
         model_byte(b, bad);
         n_total++;
         if (err_cnt !== e0 + int'(bad)) $display("FAIL rand_err%0d: got %0d expected %0d", f, err_cnt, e0 + int'(bad));
         else n_pass++;
         n_total++;
         if (overflow !== m_ovf) $display("FAIL rand_ovf%0d: got %b expected %b", f, overflow, m_ovf);
         else n_pass++;
         if ($urandom_range(0, 3) == 0 || f == 39) begin
            while (mq.size() > 0) begin
               exp = mq.pop_front();
               pop_event(obs);
               n_total++;
               if (obs !== {1'b1, exp}) $display("FAIL rand_evt%0d: got %h expected %h", f, obs, {1'b1, exp});
               else n_pass++;
            end
            n_total++;
            if (evt_valid !== 1'b0) $display("FAIL rand_drain%0d: valid %b expected 0", f, evt_valid);
            else n_pass++;
            if (m_ovf) begin
               overflow_clr = 1'b1;
               wait_clks(1);
               overflow_clr = 1'b0;
               m_ovf = 1'b0;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_make();
      test_prefix();
      test_bad_parity();
      test_overflow();
      test_full_push_pop();
      test_timeout();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ps2_key_event_rx.md
PS2_KEY_EVENT_RX -- requirements
Module: ps2_key_event_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, idle clk cycles mid-frame before frame abort.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port clrn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts head when evt_valid high.
REQ-009 SHALL have port evt_code  output  8  scan code of head event.
REQ-010 SHALL have port evt_release  output  1  head event is a key release (F0 prefix seen).
REQ-011 SHALL have port evt_ext  output  1  head event is extended (E0 prefix seen).
REQ-012 SHALL have port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 SHALL have port overflow_clr  input  1  synchronous clear of overflow.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on a bad start, parity, or stop bit, or on timeout.

Function
REQ-015 SHALL pass ps2_clk and ps2_data through 3-flop synchronisers and sample data on a detected ps2_clk falling edge (synchronised 1->0).
REQ-016 SHALL use receiver FSM states IDLE, SHIFT, CHECK; IDLE->SHIFT on a falling edge with data=0; SHIFT collects 8 data bits LSB first, then parity, then stop; ->CHECK after the stop bit; CHECK->IDLE after one cycle.
REQ-017 SHALL reject a frame when odd parity over data+parity fails or stop=0: pulse frame_err, discard the byte, and leave prefix flags unchanged.
REQ-018 SHALL, in SHIFT, abort to IDLE with a frame_err pulse when TIMEOUT_CYC clk cycles elapse without a falling edge; the counter SHALL reset on every falling edge.
REQ-019 SHALL, on a valid 0xE0 byte, set pending_ext and push nothing.
REQ-020 SHALL, on a valid 0xF0 byte, set pending_rel and push nothing.
REQ-021 SHALL, on any other valid byte, push {pending_ext, pending_rel, byte} and clear both pending flags in the same cycle.
REQ-022 SHALL make a pushed event visible on evt_* exactly 1 clk after the CHECK cycle.
REQ-023 SHALL pop the FIFO head on a cycle with evt_valid && evt_ready; evt_* SHALL hold stable while evt_valid && !evt_ready.
REQ-024 SHALL, on a push while full and not popping that cycle, drop the new event, set overflow, and keep FIFO contents intact.
REQ-025 SHALL accept a simultaneous push and pop while full; count stays full and overflow is not set.
REQ-026 SHALL accept a simultaneous push and pop while empty; the event appears on the following cycle; no bypass is allowed.
REQ-027 SHALL wrap read and write pointers modulo FIFO_DEPTH and track full/empty with a count of width $clog2(FIFO_DEPTH)+1.
REQ-028 SHALL give overflow priority over overflow_clr when a drop and a clear occur in the same cycle.

Reset
REQ-029 SHALL, with clrn low, drive evt_valid=0, overflow=0, and frame_err=0, set evt_code/evt_release/evt_ext to 0, put the FSM in IDLE, set pointers, count and timeout counter to 0, clear pending flags, and load the synchronisers with 1.
REQ-030 SHALL, on reset mid-frame, discard any partial frame; the first frame after release is decoded normally.

Structure
REQ-031 SHALL take the E0/F0 constants, the receiver state enum, and the event record width (10 bits) from shared package ps2_pkg.
REQ-032 SHALL place the FIFO in sub-module ps2_evt_fifo, parametrised by FIFO_DEPTH and WIDTH=10.

Verification
REQ-033 SHALL cover a single make: frame 0x1C -> one event code=0x1C, rel=0, ext=0, valid 1 cycle after CHECK.
REQ-034 SHALL cover prefixed sequences: E0,F0,75 -> one event code=0x75, rel=1, ext=1; a following 0x1C -> rel=0, ext=0.
REQ-035 SHALL cover a bad parity frame of 0x1C -> frame_err pulse, no event; the next good 0x1C is delivered.
REQ-036 SHALL cover overflow: FIFO_DEPTH=4, evt_ready=0, 5 make codes -> 4 events retained in order, overflow=1; an overflow_clr pulse -> overflow=0.
REQ-037 SHALL cover timeout: ps2_clk stalls high after 4 bits for TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE; the next full frame decodes correctly.
REQ-038 SHALL cover reset: clrn asserted mid-frame with 2 events queued -> evt_valid=0 immediately; after release, 0x29 -> a single event code=0x29.
